// File: rtl/i2s_tx_serializer_if.sv
// rtl/i2s_tx_serializer_if.sv - register-side and I2S bus signals of the TX serializer
interface i2s_tx_serializer_if #(
    parameter int SLOT_W = 32
);
    logic [SLOT_W-1:0] tx_data;
    logic [31:0]       controls;
    logic              tx_wr;
    logic              reg_wen;
    logic              sck;
    logic              ws;
    logic              sd;
    logic              tx_underrun;

    modport master (
        output tx_data, controls, tx_wr,
        input  reg_wen, sck, ws, sd, tx_underrun
    );

    modport slave (
        input  tx_data, controls, tx_wr,
        output reg_wen, sck, ws, sd, tx_underrun
    );
endinterface

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S master TX: holding buffer, sck divider, MSB-first slot shifter
// Optional mono mode (left word re-sent in the right slot) is built when I2S_TX_MONO_EN is defined.
module i2s_tx_serializer #(
    parameter int SLOT_W = 32,
    parameter int DIV_W  = 8
) (
    input  logic               pclk,
    input  logic               preset,
    i2s_tx_serializer_if.slave bus
);
    localparam int               BIT_W    = $clog2(SLOT_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_W - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [SLOT_W-1:0] hold_q, hold_d;
    logic [SLOT_W-1:0] shift_q, shift_d;
    logic [SLOT_W-1:0] wl_mask, slot_word;
    logic              hold_full_q, hold_full_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  div_lat_q, div_lat_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [1:0]        wl_q, wl_d, wl_sel;
    logic              sck_q, sck_d;
    logic              ws_q, ws_d;
    logic              sd_q, sd_d;
    logic              underrun_q, underrun_d;
    logic              load;
    logic              unused_ctrl;

`ifdef I2S_TX_MONO_EN
    logic              mono_q, mono_d;
    logic              load_right;
    logic [SLOT_W-1:0] left_q, left_d;
    assign unused_ctrl = ^{bus.controls[31:16], bus.controls[7:4]};
`else
    assign unused_ctrl = ^{bus.controls[31:16], bus.controls[7:3]};
`endif

    // Word length is taken live on the enable cycle so the first load already uses it.
    assign wl_sel = (state_q == IDLE) ? bus.controls[2:1] : wl_q;

    always_comb begin
        case (wl_sel)
            2'b00:   wl_mask = {SLOT_W{1'b1}} << (SLOT_W - 16);
            2'b01:   wl_mask = {SLOT_W{1'b1}} << (SLOT_W - 24);
            default: wl_mask = {SLOT_W{1'b1}};
        endcase
    end

    assign slot_word = hold_q & wl_mask;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        div_d       = div_q;
        div_lat_d   = div_lat_q;
        bit_d       = bit_q;
        wl_d        = wl_q;
        sck_d       = sck_q;
        ws_d        = ws_q;
        sd_d        = sd_q;
        underrun_d  = underrun_q;
        load        = 1'b0;
`ifdef I2S_TX_MONO_EN
        mono_d      = mono_q;
        left_d      = left_q;
        load_right  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                sck_d = 1'b0;
                ws_d  = 1'b0;
                sd_d  = 1'b0;
                div_d = '0;
                bit_d = '0;
                if (bus.controls[0]) begin
                    state_d   = RUN;
                    div_lat_d = bus.controls[8 +: DIV_W];
                    wl_d      = wl_sel;
`ifdef I2S_TX_MONO_EN
                    mono_d    = bus.controls[3];
`endif
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (!bus.controls[0]) begin
                    state_d    = IDLE;
                    sck_d      = 1'b0;
                    ws_d       = 1'b0;
                    sd_d       = 1'b0;
                    div_d      = '0;
                    bit_d      = '0;
                    shift_d    = '0;
                    underrun_d = 1'b0;
                end else if (div_q == div_lat_q) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (sck_q) begin
                        // sck falling: sd takes the shifter MSB, so period 0 carries the old LSB.
                        sd_d    = shift_q[SLOT_W-1];
                        shift_d = shift_q << 1;
                        if (bit_q == BIT_LAST) begin
                            bit_d = '0;
                            ws_d  = ~ws_q;
                            load  = 1'b1;
`ifdef I2S_TX_MONO_EN
                            load_right = ~ws_q;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            if (hold_full_q) begin
                shift_d     = slot_word;
                hold_full_d = 1'b0;
            end else begin
                shift_d    = '0;
                underrun_d = 1'b1;
            end
`ifdef I2S_TX_MONO_EN
            if (load_right && mono_q) begin
                shift_d     = left_q;
                hold_full_d = hold_full_q;
                underrun_d  = underrun_q;
            end else begin
                left_d = hold_full_q ? slot_word : '0;
            end
`endif
        end

        if (bus.tx_wr && !hold_full_q) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            div_q       <= '0;
            div_lat_q   <= '0;
            bit_q       <= '0;
            wl_q        <= '0;
            sck_q       <= 1'b0;
            ws_q        <= 1'b0;
            sd_q        <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef I2S_TX_MONO_EN
            mono_q      <= 1'b0;
            left_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            div_lat_q   <= div_lat_d;
            bit_q       <= bit_d;
            wl_q        <= wl_d;
            sck_q       <= sck_d;
            ws_q        <= ws_d;
            sd_q        <= sd_d;
            underrun_q  <= underrun_d;
`ifdef I2S_TX_MONO_EN
            mono_q      <= mono_d;
            left_q      <= left_d;
`endif
        end
    end

    assign bus.reg_wen     = ~hold_full_q;
    assign bus.sck         = sck_q;
    assign bus.ws          = ws_q;
    assign bus.sd          = sd_q;
    assign bus.tx_underrun = underrun_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - self-checking bench for i2s_tx_serializer
module tb_i2s_tx_serializer;
    logic pclk = 1'b0;
    logic preset = 1'b1;
    i2s_tx_serializer_if bus ();

    i2s_tx_serializer dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    // Frame-level model: outputs follow from cycles elapsed since enable.
    bit          m_run;
    int          m_k;
    int          m_h;
    logic [1:0]  m_wl;
    bit          m_mono;
    bit          m_full;
    logic [31:0] m_hold;
    bit          m_unr;
    logic [31:0] m_words[$];
    bit          rst_flag = 1'b1;
    logic        rx[0:2047];
    logic        prev_sck = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mask_of(input logic [1:0] wl);
        case (wl)
            2'b00:   return 32'hFFFF_0000;
            2'b01:   return 32'hFFFF_FF00;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] rx_word(input int s);
        logic [31:0] w;
        for (int n = 1; n < 32; n++) w[32-n] = rx[32*s+n];
        w[0] = rx[32*s+32];
        return w;
    endfunction

    function automatic logic [31:0] ctrl(input int div, input logic [1:0] wl, input bit mono, input bit en);
        logic [7:0] d;
        d = 8'(div);
        return {16'h0, d, 4'h0, mono, wl, en};
    endfunction

    task automatic model_reset();
        m_run  = 0;
        m_k    = 0;
        m_full = 0;
        m_hold = '0;
        m_unr  = 0;
        m_words.delete();
    endtask

    task automatic do_load(input int s);
        if ((s % 2 == 1) && m_mono) begin
            m_words.push_back(m_words[s-1]);
        end else if (m_full) begin
            m_words.push_back(m_hold & mask_of(m_wl));
            m_full = 0;
        end else begin
            m_words.push_back(32'h0);
            m_unr = 1;
        end
    endtask

    task automatic model_step();
        bit full_before;
        full_before = m_full;
        if (!m_run) begin
            if (bus.controls[0]) begin
                m_run = 1;
                m_k   = 0;
                m_h   = int'(bus.controls[15:8]) + 1;
                m_wl  = bus.controls[2:1];
`ifdef I2S_TX_MONO_EN
                m_mono = bus.controls[3];
`else
                m_mono = 0;
`endif
                m_words.delete();
                for (int i = 0; i < 2048; i++) rx[i] = 1'bx;
                do_load(0);
            end
        end else if (!bus.controls[0]) begin
            m_run = 0;
            m_unr = 0;
        end else begin
            m_k++;
            if (m_k % (64 * m_h) == 0) do_load(m_k / (64 * m_h));
        end
        if (bus.tx_wr && !full_before) begin
            m_hold = bus.tx_data;
            m_full = 1;
        end
    endtask

    initial begin
        forever begin
            logic e_sck, e_ws, e_sd;
            logic [31:0] w;
            int p, s, n;
            @(negedge pclk);
            if (preset) begin
                model_reset();
            end else begin
                if (rst_flag) begin
                    model_reset();
                    rst_flag = 0;
                end
                model_step();
            end
            e_sck = 0; e_ws = 0; e_sd = 0; p = 0;
            if (m_run) begin
                p = m_k / (2 * m_h);
                s = p / 32;
                n = p % 32;
                e_sck = ((m_k / m_h) % 2) == 1;
                e_ws  = (s % 2) == 1;
                if (n == 0) begin
                    if (s > 0) begin
                        w = m_words[s-1];
                        e_sd = w[0];
                    end
                end else begin
                    w = m_words[s];
                    e_sd = w[32-n];
                end
            end
            chk("sck", bus.sck, e_sck);
            chk("ws", bus.ws, e_ws);
            chk("sd", bus.sd, e_sd);
            chk("reg_wen", bus.reg_wen, !m_full);
            chk("tx_underrun", bus.tx_underrun, m_unr);
            if (m_run && bus.sck && !prev_sck && p < 2048) rx[p] = bus.sd;
            prev_sck = bus.sck;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
        #2;
    endtask

    task automatic write_word(input logic [31:0] d);
        bus.tx_data = d;
        bus.tx_wr   = 1'b1;
        tick(1);
        bus.tx_wr   = 1'b0;
    endtask

    initial begin
        bus.tx_data  = '0;
        bus.controls = '0;
        bus.tx_wr    = 1'b0;
        #1;
        chk("rst_sck", bus.sck, 0);
        chk("rst_reg_wen", bus.reg_wen, 1);
        chk("rst_underrun", bus.tx_underrun, 0);
        tick(2);
        preset = 1'b0;
        tick(3);

        // 32-bit word, clk_div=1; divider field change mid-run must not take effect
        bus.controls = ctrl(1, 2'b10, 0, 0);
        write_word(32'hA5A5_0F0F);
        chk("a_reg_wen_full", bus.reg_wen, 0);
        bus.controls = ctrl(1, 2'b10, 0, 1);
        tick(1);
        chk("a_reg_wen_after_load", bus.reg_wen, 1);
        bus.controls = ctrl(5, 2'b10, 0, 1);
        write_word(32'h3C3C_C3C3);
        tick(1);
        chk("a_sck_k2", bus.sck, 1);
        tick(2);
        chk("a_sck_k4", bus.sck, 0);
        tick(196);
        chk("a_left_word", rx_word(0), 32'hA5A5_0F0F);
        chk("a_underrun", bus.tx_underrun, 0);
        bus.controls = ctrl(1, 2'b10, 0, 0);
        tick(4);

        // 16-bit word length, clk_div=0
        bus.controls = ctrl(0, 2'b00, 0, 0);
        write_word(32'h1234_FFFF);
        bus.controls = ctrl(0, 2'b00, 0, 1);
        tick(1);
        write_word(32'hDEAD_BEEF);
        tick(98);
        chk("b_left_word16", rx_word(0), 32'h1234_0000);
        tick(32);
        chk("b_right_word16", rx_word(1), 32'hDEAD_0000);
        bus.controls = ctrl(0, 2'b00, 0, 0);
        tick(4);

        // underrun in the right slot, sticky until disable
        bus.controls = ctrl(0, 2'b10, 0, 0);
        write_word(32'hCAFE_F00D);
        bus.controls = ctrl(0, 2'b10, 0, 1);
        tick(1);
        tick(69);
        chk("c_underrun_set", bus.tx_underrun, 1);
        tick(70);
        chk("c_left_word", rx_word(0), 32'hCAFE_F00D);
        chk("c_right_zero", rx_word(1), 32'h0);
        chk("c_underrun_sticky", bus.tx_underrun, 1);
        bus.controls = ctrl(0, 2'b10, 0, 0);
        tick(1);
        chk("c_underrun_clear", bus.tx_underrun, 0);
        tick(3);

        // back-to-back writes: first kept, second ignored
        bus.tx_data = 32'h1111_1111;
        bus.tx_wr   = 1'b1;
        tick(1);
        bus.tx_data = 32'h2222_2222;
        tick(1);
        bus.tx_wr   = 1'b0;
        chk("d_reg_wen_full", bus.reg_wen, 0);
        bus.controls = ctrl(0, 2'b10, 0, 1);
        tick(1);
        chk("d_reg_wen_free", bus.reg_wen, 1);
        tick(69);
        chk("d_first_word", rx_word(0), 32'h1111_1111);
        bus.controls = ctrl(0, 2'b10, 0, 0);
        tick(4);

`ifdef I2S_TX_MONO_EN
        // mono: one word feeds both slots of the frame
        bus.controls = ctrl(0, 2'b10, 1, 0);
        write_word(32'h8000_0001);
        bus.controls = ctrl(0, 2'b10, 1, 1);
        tick(1);
        tick(119);
        chk("e_mono_no_underrun", bus.tx_underrun, 0);
        tick(16);
        chk("e_mono_left", rx_word(0), 32'h8000_0001);
        chk("e_mono_right", rx_word(1), 32'h8000_0001);
        bus.controls = ctrl(0, 2'b10, 1, 0);
        tick(4);
`endif

        // asynchronous reset in the middle of a slot
        bus.controls = ctrl(0, 2'b10, 0, 1);
        tick(1);
        write_word(32'h55AA_55AA);
        tick(20);
        chk("f_pre_reg_wen", bus.reg_wen, 0);
        chk("f_pre_underrun", bus.tx_underrun, 1);
        chk("f_pre_sck", bus.sck, 1);
        preset       = 1'b1;
        rst_flag     = 1'b1;
        bus.controls = '0;
        #1;
        chk("f_rst_sck", bus.sck, 0);
        chk("f_rst_ws", bus.ws, 0);
        chk("f_rst_sd", bus.sd, 0);
        chk("f_rst_underrun", bus.tx_underrun, 0);
        chk("f_rst_reg_wen", bus.reg_wen, 1);
        #1;
        preset = 1'b0;
        tick(50);
        chk("f_idle_sck", bus.sck, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
